// File: rtl/bus_write_queue.sv
`default_nettype none
// ============================================================================
// bus_write_queue : window-filtered FWFT queue of Apple II bus cycles with
//                   overflow accounting. Optional macro: BUS_WRITE_QUEUE_TIMESTAMP_EN
// Revision: 1.0
// ============================================================================
module bus_write_queue #(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] ADDR_LO       = 16'hC000,
  parameter logic [15:0] ADDR_HI       = 16'hC0FF,
  parameter int          INCLUDE_READS = 0
) (
  input  logic                       clk_logic_i,
  input  logic                       system_reset_i,
  input  logic [15:0]                addr_i,
  input  logic [7:0]                 data_i,
  input  logic                       rw_n_i,
  input  logic                       data_in_strobe_i,
  input  logic                       phi1_posedge_i,
  input  logic                       ready_i,
  input  logic                       clear_overflow_i,
  output logic                       valid_o,
  output logic [15:0]                addr_o,
  output logic [7:0]                 data_o,
  output logic                       rw_n_o,
`ifdef BUS_WRITE_QUEUE_TIMESTAMP_EN
  output logic [15:0]                timestamp_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic          READS_OK   = (INCLUDE_READS != 0);

  logic [15:0]   mem_addr [DEPTH];
  logic [7:0]    mem_data [DEPTH];
  logic          mem_rw   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_count;

  logic          in_window;
  logic          hit;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign in_window = (addr_i >= ADDR_LO) && (addr_i <= ADDR_HI);
  assign hit       = data_in_strobe_i && in_window && (!rw_n_i || READS_OK);
  assign full      = (count == FULL_COUNT);
  assign pop       = valid_o && ready_i && !system_reset_i;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push      = hit && (!full || pop) && !system_reset_i;
  assign drop      = hit && full && !pop && !system_reset_i;

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty-queue outputs are masked below.
  always_ff @(posedge clk_logic_i) begin
    if (push) begin
      mem_addr[wr_ptr] <= addr_i;
      mem_data[wr_ptr] <= data_i;
      mem_rw[wr_ptr]   <= rw_n_i;
    end
  end

  // A drop in the same cycle as a clear leaves a count of one.
  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow_i)
        drop_count <= 8'd1;
      else if (drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end else if (clear_overflow_i) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

`ifdef BUS_WRITE_QUEUE_TIMESTAMP_EN
  logic [15:0] ts_counter;
  logic [15:0] mem_ts [DEPTH];

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i)
      ts_counter <= '0;
    else if (phi1_posedge_i)
      ts_counter <= ts_counter + 16'd1;
  end

  // The pre-increment counter value is captured when a pulse coincides.
  always_ff @(posedge clk_logic_i) begin
    if (push)
      mem_ts[wr_ptr] <= ts_counter;
  end

  assign timestamp_o = valid_o ? mem_ts[rd_ptr] : 16'h0000;
`else
  logic unused_phi1;
  assign unused_phi1 = phi1_posedge_i;
`endif

  assign valid_o      = (count != '0);
  assign count_o      = count;
  assign overflow_o   = overflow;
  assign drop_count_o = drop_count;
  assign addr_o       = valid_o ? mem_addr[rd_ptr] : 16'h0000;
  assign data_o       = valid_o ? mem_data[rd_ptr] : 8'h00;
  assign rw_n_o       = valid_o ? mem_rw[rd_ptr]   : 1'b1;

endmodule
`default_nettype wire
